compare_window_stats: RTL and testbench
=======================================

// Module: compare_window_stats
// PURPOSE
//  Downstream consumer of the magnitude comparator. Accepts a stream of (a_in, b_in)
//  operand pairs together with the comparator's gt/eq/lt flags over a valid/ready handshake.
//  Over a window of WINDOW accepted samples it counts gt/eq/lt outcomes and tracks the running maximum operand.
//  It also flags any sample whose flags are not one-hot, then presents the results behind a done/ack handshake.
// PARAMETERS
//  DATA_WIDTH  4   operand width; matches comparator operand width
//  WINDOW      8   accepted samples per window (>=1)
//  CNT_WIDTH   4   counter width; must hold WINDOW ($clog2(WINDOW)+1)
// PORTS
//  clk          in   1           single clock, rising edge
//  rst          in   1           asynchronous, active-high reset
//  start        in   1           open a new window (honoured in IDLE only)
//  in_valid     in   1           sample present on a_in/b_in/flags
//  in_ready     out  1           block accepts sample this cycle
//  a_in         in   DATA_WIDTH  operand A
//  b_in         in   DATA_WIDTH  operand B
//  a_in_g_b_in  in   1           comparator flag A>B
//  a_in_e_b_in  in   1           comparator flag A==B
//  a_in_l_b_in  in   1           comparator flag A<B
//  gt_count     out  CNT_WIDTH   accepted samples with gt flag
//  eq_count     out  CNT_WIDTH   accepted samples with eq flag
//  lt_count     out  CNT_WIDTH   accepted samples with lt flag
//  max_val      out  DATA_WIDTH  largest operand seen in window
//  flag_err     out  1           sticky: some accepted sample had non-one-hot flags
//  done         out  1           window complete, results stable
//  ack          in   1           consumer has taken results
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE; in_ready=0, done=0, flag_err=0, all counts=0, max_val=0.
//  - FSM states and transitions:
//    IDLE -> RUN on start=1. Same edge clears counts, max_val, flag_err and the sample counter.
//    RUN  -> DONE on the edge that accepts sample number WINDOW.
//    DONE -> IDLE on ack=1. Results keep their values until the next start.
//  - in_ready = (state==RUN), combinational from state only; a sample is accepted when in_valid && in_ready.
//  - start is ignored in RUN and in DONE. ack is ignored outside DONE.
//  - Accepted sample, one-hot flags: increment the matching counter by 1 on the same edge.
//    Winner operand = a_in if gt, else b_in (eq or lt).
//    max_val <= winner if winner > max_val (unsigned compare).
//  - Accepted sample, flags not one-hot (000, 011, 111, ...):
//    no count increments, max_val unchanged, flag_err <= 1 (sticky until next start).
//    The sample still counts toward WINDOW.
//  - Latency: outputs reflect a sample one cycle after acceptance. done asserts the cycle after the final accept.
//  - Counts never exceed WINDOW, so no wrap occurs when CNT_WIDTH is sized as specified.
//    gt_count + eq_count + lt_count == WINDOW - (number of error samples).
//  - in_valid=0 in RUN: stall, state held; there is no timeout.
//  - rst asserted mid-window: immediate return to reset values; the partial window is discarded.
//  - WINDOW=1: RUN -> DONE after a single accept.
// STRUCTURE
//  - Shared package/header cmp_defs: state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
//    and the default DATA_WIDTH, shared with the comparator.
//  - One natural sub-module, onehot3_check: 3 flags in -> valid_onehot and flag index out.
//  - Everything else is flat: FSM, sample counter, three counters, max register.
// TESTING
//  1. rst=1 mid-RUN after 3 accepts -> all outputs zero and in_ready=0 in the same cycle (async).
//  2. start; 8 samples (a,b) = (3,1),(2,2),(0,5),(7,7),(9,4),(1,8),(6,6),(15,0), correct flags
//     -> gt=3, eq=3, lt=2, max_val=15, flag_err=0, done=1.
//  3. start; in_valid toggling every other cycle for WINDOW samples
//     -> done asserts only after the 8th accept; no sample is lost or double-counted.
//  4. start; 2nd sample flags=3'b011, others all eq
//     -> eq_count=7, flag_err=1, done still after 8 accepts.
//  5. In DONE, hold ack=0 for 5 cycles with start=1 and in_valid=1
//     -> results frozen, in_ready=0; ack=1 -> IDLE; next start clears results.
//  6. WINDOW=1 build: start, one sample (4,9) with lt
//     -> lt_count=1, max_val=9, done one cycle after accept.

Source files
------------

// File: rtl/cmp_defs.sv
// Shared definitions for the magnitude comparator and its stats consumer.
package cmp_defs;
  localparam int DEF_DATA_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    IDX_GT = 2'd0,
    IDX_EQ = 2'd1,
    IDX_LT = 2'd2
  } flag_idx_t;
endpackage

// File: rtl/onehot3_check.sv
// Purpose: classify the comparator flag triple as one-hot or not and name the set flag.
// Latency: combinational.
// Backpressure: none, pure decode.
module onehot3_check
  import cmp_defs::*;
(
  input  logic      gt,
  input  logic      eq,
  input  logic      lt,
  output logic      valid_onehot,
  output flag_idx_t idx
);

  always_comb begin
    valid_onehot = 1'b0;
    idx          = IDX_GT;
    case ({gt, eq, lt})
      3'b100: begin valid_onehot = 1'b1; idx = IDX_GT; end
      3'b010: begin valid_onehot = 1'b1; idx = IDX_EQ; end
      3'b001: begin valid_onehot = 1'b1; idx = IDX_LT; end
      default: ;
    endcase
  end

endmodule

// File: rtl/compare_window_stats.sv
// Purpose: count gt/eq/lt outcomes and the max winning operand over WINDOW accepted samples.
// Latency: results update one cycle after each accept; done the cycle after the last accept.
// Backpressure: in_ready only in RUN; results held in DONE until ack, then until next start.
module compare_window_stats
  import cmp_defs::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WINDOW     = 8,
  parameter int CNT_WIDTH  = $clog2(WINDOW) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  a_in_g_b_in,
  input  logic                  a_in_e_b_in,
  input  logic                  a_in_l_b_in,
  output logic [CNT_WIDTH-1:0]  gt_count,
  output logic [CNT_WIDTH-1:0]  eq_count,
  output logic [CNT_WIDTH-1:0]  lt_count,
  output logic [DATA_WIDTH-1:0] max_val,
  output logic                  flag_err,
  output logic                  done,
  input  logic                  ack
);

  state_t                state;
  logic [CNT_WIDTH-1:0]  sample_cnt;
  logic                  valid_onehot;
  flag_idx_t             idx;
  logic [DATA_WIDTH-1:0] winner;
  logic                  accept;
  logic                  last_sample;

  onehot3_check u_onehot (
    .gt           (a_in_g_b_in),
    .eq           (a_in_e_b_in),
    .lt           (a_in_l_b_in),
    .valid_onehot (valid_onehot),
    .idx          (idx)
  );

  assign in_ready    = (state == RUN);
  assign accept      = in_valid && in_ready;
  // Eq samples pick b_in; a_in == b_in there, so the choice only matters for lt.
  assign winner      = (idx == IDX_GT) ? a_in : b_in;
  assign last_sample = (sample_cnt == CNT_WIDTH'(WINDOW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      gt_count   <= '0;
      eq_count   <= '0;
      lt_count   <= '0;
      max_val    <= '0;
      flag_err   <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            sample_cnt <= '0;
            gt_count   <= '0;
            eq_count   <= '0;
            lt_count   <= '0;
            max_val    <= '0;
            flag_err   <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            sample_cnt <= sample_cnt + CNT_WIDTH'(1);
            if (valid_onehot) begin
              case (idx)
                IDX_GT:  gt_count <= gt_count + CNT_WIDTH'(1);
                IDX_EQ:  eq_count <= eq_count + CNT_WIDTH'(1);
                default: lt_count <= lt_count + CNT_WIDTH'(1);
              endcase
              if (winner > max_val) max_val <= winner;
            end else begin
              flag_err <= 1'b1;
            end
            if (last_sample) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (ack) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_compare_window_stats.sv
// Directed and randomized windows checked against a queue-based model of the window statistics.
module tb_compare_window_stats;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] f;  // {gt, eq, lt}
  } smp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, in_valid, in_ready, ack;
  logic [3:0] a_in, b_in;
  logic       fg, fe, fl;
  logic [3:0] gt_count, eq_count, lt_count, max_val;
  logic       flag_err, done;

  logic       s1_start, s1_in_valid, s1_in_ready, s1_ack;
  logic [3:0] s1_a, s1_b;
  logic       s1_fg, s1_fe, s1_fl;
  logic [0:0] s1_gt, s1_eq, s1_lt;
  logic [3:0] s1_max;
  logic       s1_err, s1_done;

  int checks = 0;
  int errors = 0;

  smp_t q[$];
  int   exp_gt, exp_eq, exp_lt, exp_max, exp_err;

  always #5 clk = ~clk;

  compare_window_stats #(.DATA_WIDTH(4), .WINDOW(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .a_in_g_b_in(fg), .a_in_e_b_in(fe), .a_in_l_b_in(fl),
    .gt_count(gt_count), .eq_count(eq_count), .lt_count(lt_count), .max_val(max_val),
    .flag_err(flag_err), .done(done), .ack(ack)
  );

  compare_window_stats #(.DATA_WIDTH(4), .WINDOW(1), .CNT_WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(s1_start), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .a_in(s1_a), .b_in(s1_b), .a_in_g_b_in(s1_fg), .a_in_e_b_in(s1_fe), .a_in_l_b_in(s1_fl),
    .gt_count(s1_gt), .eq_count(s1_eq), .lt_count(s1_lt), .max_val(s1_max),
    .flag_err(s1_err), .done(s1_done), .ack(s1_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] true_flags(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? 3'b100 : (a == b) ? 3'b010 : 3'b001;
  endfunction

  function automatic logic [2:0] bad_flags();
    logic [2:0] f;
    f = 3'(($urandom_range(0, 3)) * 2 + 3);  // 3,5,7,9->1? filtered below
    while ($countones(f) == 1) f = 3'($urandom_range(0, 7));
    return f;
  endfunction

  // Window statistics straight from the rules: count flag kinds, track largest winner.
  task automatic compute_expected();
    exp_gt = 0; exp_eq = 0; exp_lt = 0; exp_max = 0; exp_err = 0;
    foreach (q[i]) begin
      if ($countones(q[i].f) != 1) exp_err = 1;
      else begin
        int w;
        if (q[i].f[2]) exp_gt++;
        if (q[i].f[1]) exp_eq++;
        if (q[i].f[0]) exp_lt++;
        w = q[i].f[2] ? int'(q[i].a) : int'(q[i].b);
        if (w > exp_max) exp_max = w;
      end
    end
  endtask

  task automatic check_results(input string tag);
    chk({tag, "_gt"}, gt_count, exp_gt);
    chk({tag, "_eq"}, eq_count, exp_eq);
    chk({tag, "_lt"}, lt_count, exp_lt);
    chk({tag, "_max"}, max_val, exp_max);
    chk({tag, "_err"}, flag_err, exp_err);
  endtask

  // Called at a negedge; returns #1 after the accepting posedge.
  task automatic send(input smp_t s);
    int n;
    a_in = s.a; b_in = s.b; {fg, fe, fl} = s.f; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("start_ready", in_ready, 1);
    chk("start_gt_clr", gt_count, 0);
    chk("start_max_clr", max_val, 0);
    chk("start_err_clr", flag_err, 0);
  endtask

  // gap < 0 picks a random idle gap per sample.
  task automatic feed(input int gap);
    foreach (q[i]) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) @(negedge clk);
      send(q[i]);
      @(negedge clk);
      chk("done_timing", done, (i == q.size() - 1) ? 1 : 0);
    end
    chk("done_ready_low", in_ready, 0);
  endtask

  task automatic ack_window();
    ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    chk("ack_done_low", done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 0; in_valid = 0; ack = 0; a_in = 0; b_in = 0; {fg, fe, fl} = 3'b000;
    s1_start = 0; s1_in_valid = 0; s1_ack = 0; s1_a = 0; s1_b = 0; {s1_fg, s1_fe, s1_fl} = 3'b000;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_counts", {gt_count, eq_count, lt_count, max_val}, 0);
    chk("rst_err", flag_err, 0);
    rst = 1'b0;

    // Reset mid-window after three accepts
    do_start();
    send('{a: 4'd9, b: 4'd2, f: 3'b100});
    send('{a: 4'd3, b: 4'd3, f: 3'b010});
    send('{a: 4'd1, b: 4'd6, f: 3'b000});
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready", in_ready, 0);
    chk("midrst_counts", {gt_count, eq_count, lt_count, max_val}, 0);
    chk("midrst_err_done", {flag_err, done}, 0);
    @(negedge clk) rst = 1'b0;

    // Fixed window with correct flags
    q.delete();
    q.push_back('{a: 4'd3,  b: 4'd1, f: 3'b100});
    q.push_back('{a: 4'd2,  b: 4'd2, f: 3'b010});
    q.push_back('{a: 4'd0,  b: 4'd5, f: 3'b001});
    q.push_back('{a: 4'd7,  b: 4'd7, f: 3'b010});
    q.push_back('{a: 4'd9,  b: 4'd4, f: 3'b100});
    q.push_back('{a: 4'd1,  b: 4'd8, f: 3'b001});
    q.push_back('{a: 4'd6,  b: 4'd6, f: 3'b010});
    q.push_back('{a: 4'd15, b: 4'd0, f: 3'b100});
    do_start();
    feed(0);
    compute_expected();
    check_results("fixed");
    chk("fixed_gt_const", gt_count, 3);
    chk("fixed_max_const", max_val, 15);
    ack_window();

    // in_valid toggling, random operands with true flags
    q.delete();
    for (int i = 0; i < 8; i++) begin
      smp_t s;
      s.a = 4'($urandom_range(0, 15)); s.b = 4'($urandom_range(0, 15));
      s.f = true_flags(s.a, s.b);
      q.push_back(s);
    end
    do_start();
    feed(1);
    compute_expected();
    check_results("toggle");
    ack_window();

    // All-eq window with one bad flag triple
    q.delete();
    for (int i = 0; i < 8; i++) begin
      smp_t s;
      s.a = 4'($urandom_range(0, 15)); s.b = s.a; s.f = 3'b010;
      if (i == 1) s.f = 3'b011;
      q.push_back(s);
    end
    do_start();
    feed(0);
    compute_expected();
    check_results("bad_flag");
    chk("bad_flag_eq_const", eq_count, 7);

    // DONE holds against start/in_valid until ack
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; in_valid = 1'b1; ack = 1'b0;
      a_in = 4'($urandom_range(0, 15)); b_in = 4'($urandom_range(0, 15)); {fg, fe, fl} = 3'b100;
      @(negedge clk);
      check_results("frozen");
      chk("frozen_ready", in_ready, 0);
      chk("frozen_done", done, 1);
    end
    start = 1'b0; in_valid = 1'b0;
    ack_window();
    check_results("after_ack");
    chk("after_ack_ready", in_ready, 0);
    do_start();
    ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    chk("ack_in_run_ignored", in_ready, 1);

    // Random windows mixing gaps and non-one-hot flags
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int w = 0; w < 4; w++) begin
      q.delete();
      for (int i = 0; i < 8; i++) begin
        smp_t s;
        s.a = 4'($urandom_range(0, 15)); s.b = 4'($urandom_range(0, 15));
        s.f = ($urandom_range(0, 4) == 0) ? bad_flags() : true_flags(s.a, s.b);
        q.push_back(s);
      end
      do_start();
      feed(-1);
      compute_expected();
      check_results("rand");
      chk("rand_sum", 32'(gt_count) + 32'(eq_count) + 32'(lt_count),
          32'(8 - q.size() + exp_gt + exp_eq + exp_lt));
      ack_window();
    end

    // WINDOW=1 instance
    @(negedge clk) s1_start = 1'b1;
    @(negedge clk) s1_start = 1'b0;
    chk("w1_ready", s1_in_ready, 1);
    s1_a = 4'd4; s1_b = 4'd9; {s1_fg, s1_fe, s1_fl} = 3'b001; s1_in_valid = 1'b1;
    @(negedge clk) s1_in_valid = 1'b0;
    chk("w1_lt", s1_lt, 1);
    chk("w1_gt_eq", {s1_gt, s1_eq}, 0);
    chk("w1_max", s1_max, 9);
    chk("w1_done", s1_done, 1);
    chk("w1_ready_low", s1_in_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
